// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, standard IV, bitwise helper
// functions and the compression FSM state encoding.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/mod_choice.sv
// Bitwise SHA-2 choice function: each bit of x selects y (1) or z (0).
module mod_choice (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic [31:0] ch
);

    assign ch = (x & y) ^ (~x & z);

endmodule

// File: rtl/sha256_msg_schedule.sv
// Sliding 16-word message schedule window; slot 0 always presents W[t].
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [0:511] m,
    output logic [31:0]  w_t
);

    logic [31:0] window_reg [0:15];
    logic [31:0] load_word  [0:15];
    logic [31:0] shift_word [0:15];
    logic [31:0] new_word;

    // Window holds W[t..t+15], so the word entering slot 15 is W[t+16].
    assign new_word = small_s1(window_reg[14]) + window_reg[9]
                    + small_s0(window_reg[1]) + window_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            assign load_word[gi] = m[gi*32 +: 32];
            if (gi < 15) begin : g_mid
                assign shift_word[gi] = window_reg[gi+1];
            end else begin : g_last
                assign shift_word[gi] = new_word;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) window_reg[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) window_reg[i] <= load_word[i];
        end else if (shift) begin
            for (int i = 0; i < 16; i++) window_reg[i] <= shift_word[i];
        end
    end

    assign w_t = window_reg[0];

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per clock, digest added to the
// latched chaining value in a final cycle that also pulses valid.
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:255] h_in,
    input  logic [0:511] m,
    output logic         busy,
    output logic         valid,
    output logic [0:255] h_out
);

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [6:0]  t_reg;
    logic [31:0] work_reg [0:7];
    logic [31:0] hin_reg  [0:7];
    logic [31:0] hout_reg [0:7];
    logic        valid_reg;
    logic        accept;
    logic        do_round;
    logic [31:0] w_t;
    logic [31:0] ch;
    logic [31:0] t1;
    logic [31:0] t2;

    // The valid cycle is already IDLE, so it is masked to keep start ignored there.
    assign accept   = (state_reg == ST_IDLE) && start && !valid_reg;
    assign do_round = (state_reg == ST_ROUND);

    mod_choice u_choice (
        .x  (work_reg[4]),
        .y  (work_reg[5]),
        .z  (work_reg[6]),
        .ch (ch)
    );

    sha256_msg_schedule u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (do_round),
        .m     (m),
        .w_t   (w_t)
    );

    always_comb begin
        t1 = work_reg[7] + big_s1(work_reg[4]) + ch + K[t_reg[5:0]] + w_t;
        t2 = big_s0(work_reg[0]) + maj(work_reg[0], work_reg[1], work_reg[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_ROUND;
            ST_ROUND: if (t_reg == LAST_T) state_next = ST_FINAL;
            ST_FINAL: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg     <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                work_reg[i] <= '0;
                hin_reg[i]  <= '0;
                hout_reg[i] <= '0;
            end
        end else begin
            valid_reg <= 1'b0;
            if (accept) begin
                t_reg <= '0;
                for (int i = 0; i < 8; i++) begin
                    hin_reg[i]  <= h_in[i*32 +: 32];
                    work_reg[i] <= h_in[i*32 +: 32];
                end
            end else if (do_round) begin
                work_reg[7] <= work_reg[6];
                work_reg[6] <= work_reg[5];
                work_reg[5] <= work_reg[4];
                work_reg[4] <= work_reg[3] + t1;
                work_reg[3] <= work_reg[2];
                work_reg[2] <= work_reg[1];
                work_reg[1] <= work_reg[0];
                work_reg[0] <= t1 + t2;
                t_reg       <= t_reg + 7'd1;
            end else if (state_reg == ST_FINAL) begin
                for (int i = 0; i < 8; i++) hout_reg[i] <= hin_reg[i] + work_reg[i];
                valid_reg <= 1'b1;
                t_reg     <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hout
            assign h_out[gi*32 +: 32] = hout_reg[gi];
        end
    endgenerate

    assign busy  = (state_reg != ST_IDLE);
    assign valid = valid_reg;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Bench for sha256_compress_core: plain SHA-256 reference model, cycle-accurate
// busy/valid/digest expectations, known-answer vectors and randomised blocks.
module tb_sha256_compress_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [0:255] h_in = '0;
    logic [0:511] m = '0;
    logic         busy;
    logic         valid;
    logic [0:255] h_out;

    sha256_compress_core #(.ROUNDS(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .h_in  (h_in),
        .m     (m),
        .busy  (busy),
        .valid (valid),
        .h_out (h_out)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] TB_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_448A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_448B  = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word expansion first, then 64 rounds.
    function automatic logic [255:0] model(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    int passes = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Transaction tracker: when a start is accepted and what digest it must produce.
    int           cyc = 0;
    int           acc = -1000;
    bit           active = 1'b0;
    logic [255:0] exp_digest = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
        end else begin
            if (start && (!active || cyc >= acc + 66)) begin
                acc        <= cyc + 1;
                active     <= 1'b1;
                exp_digest <= model(h_in, m);
            end
            cyc <= cyc + 1;
        end
    end

    // Per-cycle compare: busy for 65 cycles, valid on the 66th, h_out held between valids.
    logic [255:0] held = '0;
    bit           exp_busy, exp_valid;

    always @(negedge clk) begin
        if (rst) begin
            held = '0;
            chk("rst_busy", busy, 0);
            chk("rst_valid", valid, 0);
            chk("rst_h_out", h_out, '0);
        end else begin
            exp_busy  = active && cyc >= acc && cyc <= acc + 64;
            exp_valid = active && cyc == acc + 65;
            if (exp_valid) held = exp_digest;
            chk("busy", busy, exp_busy);
            chk("valid", valid, exp_valid);
            chk("h_out", h_out, held);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_block(input string name, input logic [255:0] hin, input logic [511:0] blk,
                             input bit scramble, input int pulse_a, input int pulse_b,
                             output logic [255:0] digest);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        h_in  = hin;
        m     = blk;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (scramble) begin
            for (int i = 0; i < 8; i++)  h_in[i*32 +: 32] = $urandom;
            for (int i = 0; i < 16; i++) m[i*32 +: 32]    = $urandom;
        end
        for (int k = 0; k < 100 && !seen; k++) begin
            start = (k == pulse_a || k == pulse_b);
            if (valid) seen = 1'b1;
            else begin
                if (busy) busy_cnt++;
                tick(1);
            end
        end
        start  = 1'b0;
        digest = h_out;
        chk({name, "_valid_seen"}, seen, 1);
        chk({name, "_busy_cycles"}, busy_cnt, 65);
        chk({name, "_digest"}, digest, model(hin, blk));
        $display("block %s: h_in=%h digest=%h busy_cycles=%0d", name, hin, digest, busy_cnt);
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] dig, dig1, hr;
        logic [511:0] br;

        chk("model_abc", model(TB_IV, BLK_ABC), DIG_ABC);
        chk("model_empty", model(TB_IV, BLK_EMPTY), DIG_EMPTY);

        tick(3);
        rst = 1'b0;
        tick(2);

        run_block("abc", TB_IV, BLK_ABC, 1'b0, -1, -1, dig);
        chk("abc_literal", dig, DIG_ABC);
        run_block("empty", TB_IV, BLK_EMPTY, 1'b0, -1, -1, dig);
        chk("empty_literal", dig, DIG_EMPTY);
        run_block("msg448_b1", TB_IV, BLK_448A, 1'b0, -1, -1, dig1);
        run_block("msg448_b2", dig1, BLK_448B, 1'b0, -1, -1, dig);
        chk("msg448_literal", dig, DIG_448);

        run_block("abc_repulse", TB_IV, BLK_ABC, 1'b0, 5, 40, dig);
        chk("abc_repulse_literal", dig, DIG_ABC);

        h_in  = TB_IV;
        m     = BLK_EMPTY;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(30);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        $display("reset mid-run applied and released");
        run_block("empty_after_rst", TB_IV, BLK_EMPTY, 1'b0, -1, -1, dig);
        chk("empty_after_rst_literal", dig, DIG_EMPTY);

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++)  hr[255-32*i -: 32] = $urandom;
            for (int i = 0; i < 16; i++) br[511-32*i -: 32] = $urandom;
            run_block("scrambled", hr, br, 1'b1, -1, -1, dig);
        end

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++)  hr[255-32*i -: 32] = $urandom;
            for (int i = 0; i < 16; i++) br[511-32*i -: 32] = $urandom;
            run_block("random", hr, br, 1'b0, -1, -1, dig);
        end

        tick(3);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
